// File: rtl/f2fx_pkg.sv
// f2fx_pkg: IEEE-754 single-precision field layout and sample classes for the float-to-fixed converter.
package f2fx_pkg;

    localparam int EXP_W    = 8;
    localparam int MAN_W    = 23;
    localparam int EXP_BIAS = 127;
    localparam int EXP_MAX  = 255;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exponent;
        logic [MAN_W-1:0] mantissa;
    } float32_t;

    typedef enum logic [1:0] {ZERO, NORMAL, INF, NAN} f2fx_class_e;

    // Denormals share the all-zero exponent and are flushed together with true zero.
    function automatic f2fx_class_e f2fx_classify(input float32_t f);
        return (f.exponent == '0) ? ZERO :
               (f.exponent != EXP_W'(EXP_MAX)) ? NORMAL :
               (f.mantissa == '0) ? INF : NAN;
    endfunction

endpackage

// File: rtl/f2fx_align_sat.sv
// f2fx_align_sat: combinational shift, truncate or round, negate and saturate of a classified float.
// Round-to-nearest-even on the discarded bits when F2FX_ROUND_EN is defined, truncation otherwise.
module f2fx_align_sat
    import f2fx_pkg::*;
#(
    parameter int OUT_W  = 16,
    parameter int FRAC_W = 0
) (
    input  logic             sign_i,
    input  logic [EXP_W-1:0] exp_i,
    input  logic [MAN_W:0]   man_i,
    input  f2fx_class_e      cls_i,
    output logic [OUT_W-1:0] fixed_o,
    output logic             sat_o,
    output logic             nan_o
);

    localparam logic signed [9:0] OFS     = 10'(FRAC_W - EXP_BIAS);
    localparam logic signed [9:0] SH_OVF  = 10'(OUT_W);
    localparam logic signed [9:0] SH_MAN  = 10'(MAN_W);
    localparam logic signed [9:0] SH_MIN  = -10'sd1;
    localparam logic [32:0]       LIM     = 33'd1 << (OUT_W - 1);
    localparam logic [OUT_W-1:0]  MAX_POS = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0]  MAX_NEG = ~MAX_POS;

    logic signed [9:0] sh;
    logic              ovf;
    logic              live;
    logic              right;
    logic              rnd;
    logic              big;
    logic [4:0]        r;
    logic [3:0]        l;
    logic [MAN_W:0]    int_part;
    logic [32:0]       mag;
    logic [32:0]       mag_r;

    // sh is the bit position the hidden one lands on in the scaled result.
    assign sh    = $signed({2'b00, exp_i}) + OFS;
    assign ovf   = sh >= SH_OVF;
    assign live  = !ovf && (sh >= SH_MIN);
    assign right = sh <= SH_MAN;
    assign r     = 5'(SH_MAN - sh);
    assign l     = 4'(sh - SH_MAN);

`ifdef F2FX_ROUND_EN
    logic [2*MAN_W+1:0] wide;
    assign wide     = {man_i, {(MAN_W+1){1'b0}}} >> r;
    assign int_part = wide[2*MAN_W+1:MAN_W+1];
    assign rnd      = live && right && wide[MAN_W] && ((|wide[MAN_W-1:0]) || mag[0]);
`else
    assign int_part = man_i >> r;
    assign rnd      = 1'b0;
`endif

    assign mag   = !live ? '0 : right ? {9'b0, int_part} : ({9'b0, man_i} << l);
    assign mag_r = mag + 33'(rnd);
    // Exactly 2^(OUT_W-1) still fits as the most negative value.
    assign big   = ovf || (sign_i ? (mag_r > LIM) : (mag_r >= LIM));

    always_comb begin
        fixed_o = (cls_i == NAN || cls_i == ZERO) ? '0 :
                  (cls_i == INF || big) ? (sign_i ? MAX_NEG : MAX_POS) :
                  sign_i ? -mag_r[OUT_W-1:0] : mag_r[OUT_W-1:0];
        sat_o   = (cls_i == INF) || (cls_i == NORMAL && big);
        nan_o   = cls_i == NAN;
    end

endmodule

// File: rtl/float_to_fixed_pipe.sv
// float_to_fixed_pipe: two-stage valid/ready pipeline converting IEEE-754 single to signed Q fixed point.
// Define F2FX_ROUND_EN for round-to-nearest-even instead of truncation toward zero.
module float_to_fixed_pipe
    import f2fx_pkg::*;
#(
    parameter int OUT_W  = 16,
    parameter int FRAC_W = 0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [31:0]      i_float,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [OUT_W-1:0] o_fixed,
    output logic             o_sat,
    output logic             o_nan
);

    float32_t         f;
    f2fx_class_e      cls_d;
    f2fx_class_e      cls_q;
    logic             en1;
    logic             en2;
    logic             v1_q;
    logic             v2_q;
    logic             sign_q;
    logic [EXP_W-1:0] exp_q;
    logic [MAN_W:0]   man_q;
    logic [OUT_W-1:0] fixed_d;
    logic [OUT_W-1:0] fixed_q;
    logic             sat_d;
    logic             sat_q;
    logic             nan_d;
    logic             nan_q;

    assign f     = i_float;
    assign cls_d = f2fx_classify(f);

    // Ready ripples back combinationally so a full pipe keeps streaming while downstream accepts.
    assign en2     = !v2_q || i_ready;
    assign en1     = !v1_q || en2;
    assign o_ready = en1;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            v1_q   <= 1'b0;
            sign_q <= 1'b0;
            exp_q  <= '0;
            man_q  <= '0;
            cls_q  <= ZERO;
        end else if (en1) begin
            v1_q <= i_valid;
            if (i_valid) begin
                sign_q <= f.sign;
                exp_q  <= f.exponent;
                man_q  <= {1'b1, f.mantissa};
                cls_q  <= cls_d;
            end
        end
    end

    f2fx_align_sat #(
        .OUT_W  (OUT_W),
        .FRAC_W (FRAC_W)
    ) u_align (
        .sign_i  (sign_q),
        .exp_i   (exp_q),
        .man_i   (man_q),
        .cls_i   (cls_q),
        .fixed_o (fixed_d),
        .sat_o   (sat_d),
        .nan_o   (nan_d)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            v2_q    <= 1'b0;
            fixed_q <= '0;
            sat_q   <= 1'b0;
            nan_q   <= 1'b0;
        end else if (en2) begin
            v2_q <= v1_q;
            if (v1_q) begin
                fixed_q <= fixed_d;
                sat_q   <= sat_d;
                nan_q   <= nan_d;
            end
        end
    end

    assign o_valid = v2_q;
    assign o_fixed = fixed_q;
    assign o_sat   = sat_q;
    assign o_nan   = nan_q;

endmodule

// File: tb/tb_float_to_fixed_pipe.sv
// tb_float_to_fixed_pipe: Q16.0 and Q8.8 converters side by side against a table and an arithmetic model.
// Expectations follow F2FX_ROUND_EN when it is defined for the build.
module tb_float_to_fixed_pipe;

`ifdef F2FX_ROUND_EN
    localparam bit RND = 1'b1;
`else
    localparam bit RND = 1'b0;
`endif

    typedef struct {
        logic [31:0] f;
        logic [17:0] e0;
        logic [17:0] e8;
    } vec_t;

    typedef struct {
        logic [17:0] e0;
        logic [17:0] e8;
        int          cyc;
        bit          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        i_rst;
    logic        i_valid;
    logic        i_ready;
    logic [31:0] i_float;
    logic        o_ready0, o_valid0, o_sat0, o_nan0;
    logic        o_ready8, o_valid8, o_sat8, o_nan8;
    logic [15:0] o_fixed0, o_fixed8;

    vec_t        tv[17];
    exp_t        q[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          n_pop = 0;
    bit          free_flow = 1'b0;
    bit          hold_v = 1'b0;
    logic [17:0] hold0, hold8;

    always #5 clk = ~clk;

    float_to_fixed_pipe #(.OUT_W(16), .FRAC_W(0)) dut0 (
        .i_clk(clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready0), .i_float(i_float),
        .o_valid(o_valid0), .i_ready(i_ready), .o_fixed(o_fixed0), .o_sat(o_sat0), .o_nan(o_nan0)
    );

    float_to_fixed_pipe #(.OUT_W(16), .FRAC_W(8)) dut8 (
        .i_clk(clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready8), .i_float(i_float),
        .o_valid(o_valid8), .i_ready(i_ready), .o_fixed(o_fixed8), .o_sat(o_sat8), .o_nan(o_nan8)
    );

    wire [17:0] out0 = {o_nan0, o_sat0, o_fixed0};
    wire [17:0] out8 = {o_nan8, o_sat8, o_fixed8};

    // Result packed as {nan, sat, fixed[15:0]} for a Q(16-frac).frac target.
    function automatic logic [17:0] ref_conv(input logic [31:0] f, input int frac);
        int          e, k;
        longint      m, d, mag, rem;
        logic [15:0] fx;
        e = int'(f[30:23]);
        m = longint'({1'b1, f[22:0]});
        k = e - 127 + frac - 23;
        if (e == 0) return 18'h0;
        if (e == 255) return (f[22:0] != 0) ? 18'h20000 : (f[31] ? 18'h18000 : 18'h17FFF);
        if (k > 20) mag = longint'(1) << 40;
        else if (k >= 0) mag = m << k;
        else if (k < -40) mag = 0;
        else begin
            d = longint'(1) << (-k);
            mag = m / d;
            rem = m % d;
            if (RND && (2 * rem > d || (2 * rem == d && mag % 2 == 1))) mag++;
        end
        if (f[31] ? mag > 32768 : mag > 32767) return f[31] ? 18'h18000 : 18'h17FFF;
        fx = 16'(f[31] ? -mag : mag);
        return {2'b00, fx};
    endfunction

    function automatic logic [31:0] rnd_float();
        int          sel;
        logic [31:0] f;
        sel = $urandom_range(0, 9);
        f = $urandom;
        if (sel == 0) f[30:23] = 8'd0;
        else if (sel == 1) begin
            f[30:23] = 8'd255;
            if ($urandom_range(0, 1) == 0) f[22:0] = '0;
        end else begin
            f[30:23] = 8'($urandom_range(110, 150));
            if (sel == 3) f[12:0] = 13'h1000;
        end
        return f;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    // One clock: drive, settle, check against the in-flight queue, then advance to the next falling edge.
    task automatic cycle(input bit v, input logic [31:0] f, input bit rdy, input logic [17:0] e0,
                         input logic [17:0] e8, output bit acc);
        exp_t e;
        i_valid = v;
        i_float = f;
        i_ready = rdy;
        #1;
        chk("o_ready", {30'd0, o_ready8, o_ready0}, (q.size() == 2 && !rdy) ? 32'd0 : 32'd3);
        if (hold_v) begin
            chk("hold_q16", 32'(out0), 32'(hold0));
            chk("hold_q8", 32'(out8), 32'(hold8));
        end
        hold_v = 1'b0;
        if (q.size() == 0) chk("idle_valid", {30'd0, o_valid8, o_valid0}, 32'd0);
        else if (o_valid0 && rdy) begin
            e = q.pop_front();
            n_pop++;
            chk("out_q16", 32'(out0), 32'(e.e0));
            chk("out_q8", 32'(out8), 32'(e.e8));
            if (e.lat) chk("latency", cyc - e.cyc, 32'd2);
        end else if (o_valid0) begin
            hold_v = 1'b1;
            hold0 = out0;
            hold8 = out8;
        end
        acc = v && o_ready0;
        if (acc) q.push_back('{e0, e8, cyc, free_flow});
        cyc++;
        @(negedge clk);
    endtask

    task automatic drain();
        bit acc;
        for (int i = 0; i < 20 && q.size() > 0; i++) cycle(1'b0, 32'h0, 1'b1, 18'h0, 18'h0, acc);
        chk("drain_empty", q.size(), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit          acc;
        int          idx, p0;
        logic [31:0] bp_f[8];
        logic [31:0] f;
        tv[0]  = '{32'h40600000, RND ? 18'h00004 : 18'h00003, 18'h00380};
        tv[1]  = '{32'h40200000, 18'h00002, 18'h00280};
        tv[2]  = '{32'hBF800000, 18'h0FFFF, 18'h0FF00};
        tv[3]  = '{32'h3B800000, 18'h00000, 18'h00001};
        tv[4]  = '{32'h3B000000, 18'h00000, 18'h00000};
        tv[5]  = '{32'h471C4000, 18'h17FFF, 18'h17FFF};
        tv[6]  = '{32'hC7000000, 18'h08000, 18'h18000};
        tv[7]  = '{32'hFF800000, 18'h18000, 18'h18000};
        tv[8]  = '{32'h7FC00000, 18'h20000, 18'h20000};
        tv[9]  = '{32'h80000000, 18'h00000, 18'h00000};
        tv[10] = '{32'h00000001, 18'h00000, 18'h00000};
        tv[11] = '{32'h3FC00000, RND ? 18'h00002 : 18'h00001, 18'h00180};
        tv[12] = '{32'h46FFFE00, 18'h07FFF, 18'h17FFF};
        tv[13] = '{32'h47000000, 18'h17FFF, 18'h17FFF};
        tv[14] = '{32'hC6FFFF00, RND ? 18'h08000 : 18'h08001, 18'h18000};
        tv[15] = '{32'h46FFFF00, RND ? 18'h17FFF : 18'h07FFF, 18'h17FFF};
        tv[16] = '{32'h7F800000, 18'h17FFF, 18'h17FFF};
        bp_f = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                 32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};

        i_rst = 1'b1;
        i_valid = 1'b0;
        i_ready = 1'b1;
        i_float = 32'h0;
        #3;
        chk("rst_valid", {30'd0, o_valid8, o_valid0}, 32'd0);
        chk("rst_out_q16", 32'(out0), 32'd0);
        chk("rst_out_q8", 32'(out8), 32'd0);
        @(negedge clk);
        i_rst = 1'b0;

        free_flow = 1'b1;
        foreach (tv[i]) cycle(1'b1, tv[i].f, 1'b1, tv[i].e0, tv[i].e8, acc);
        drain();

        free_flow = 1'b0;
        idx = 0;
        p0 = n_pop;
        for (int k = 0; k < 80 && (idx < 8 || q.size() > 0); k++) begin
            f = bp_f[idx < 8 ? idx : 0];
            cycle(idx < 8, f, (k % 4 == 0) || (k % 4 == 3), ref_conv(f, 0), ref_conv(f, 8), acc);
            if (acc) idx++;
        end
        chk("bp_count", n_pop - p0, 32'd8);

        cycle(1'b1, 32'h40A00000, 1'b1, ref_conv(32'h40A00000, 0), ref_conv(32'h40A00000, 8), acc);
        cycle(1'b1, 32'h40C00000, 1'b1, ref_conv(32'h40C00000, 0), ref_conv(32'h40C00000, 8), acc);
        i_valid = 1'b0;
        #2;
        i_rst = 1'b1;
        #1;
        chk("async_rst_valid", {30'd0, o_valid8, o_valid0}, 32'd0);
        chk("async_rst_out", 32'(out0), 32'd0);
        q.delete();
        hold_v = 1'b0;
        @(negedge clk);
        i_rst = 1'b0;
        for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 1'b1, 18'h0, 18'h0, acc);
        free_flow = 1'b1;
        cycle(1'b1, 32'h41200000, 1'b1, ref_conv(32'h41200000, 0), ref_conv(32'h41200000, 8), acc);
        drain();

        free_flow = 1'b0;
        for (int i = 0; i < 400; i++) begin
            f = rnd_float();
            cycle($urandom_range(0, 3) != 0, f, $urandom_range(0, 3) != 0, ref_conv(f, 0), ref_conv(f, 8), acc);
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/float_to_fixed_pipe.md
Name: float_to_fixed_pipe

Overview:
- Pipelined, parametrised IEEE-754 single-precision to signed fixed-point converter with valid/ready handshake on both sides.
- Generalises the earlier combinational 16-bit integer converter:
  - configurable output width and fractional bits
  - saturation on overflow
  - NaN/Inf/denormal handling
  - per-sample status flags
- Sits between float-domain coefficient/sample sources and the fixed-point filter datapath.

Parameters:
- OUT_W, 16, output width in bits, two's complement; legal range 2..32.
- FRAC_W, 0, number of fractional bits in output (Q(OUT_W-FRAC_W).FRAC_W); legal range 0..OUT_W-1.

Ports:
- i_clk  in  1  clock, all logic on rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_valid  in  1  input sample valid.
- o_ready  out  1  converter can accept input this cycle.
- i_float  in  32  IEEE-754 single-precision input.
- o_valid  out  1  output sample valid.
- i_ready  in  1  downstream accepts output this cycle.
- o_fixed  out  OUT_W  signed fixed-point result.
- o_sat  out  1  result was clamped (overflow or ±Inf); qualified by o_valid.
- o_nan  out  1  input was NaN, result forced to 0; qualified by o_valid.

Behaviour:
- Reset (async assert, sync release on i_clk): both stage valids 0, o_valid=0, o_fixed=0, o_sat=0, o_nan=0.
- Pipeline:
  - Two register stages, latency 2 cycles from accepted input to o_valid with no stall.
  - Throughput 1 sample/cycle.
  - Stage 1 registers sign, exponent, {1,mantissa}, and class (ZERO, NORMAL, INF, NAN).
  - Stage 2 registers the shifted, rounded, negated, saturated result plus flags.
- Handshake:
  - Advance enables: en2 = !v2 | i_ready; en1 = !v1 | en2; o_ready = en1.
  - Combinational ready chain; no bubbles under continuous flow.
  - Transfer occurs when valid & ready are both high.
  - Data and flags hold stable while o_valid=1 and i_ready=0.
  - Input with i_valid=1, o_ready=0 is not captured.
- Conversion: value = (-1)^s · 1.m · 2^(e-127); target = value·2^FRAC_W.
  - Magnitude is truncated toward zero, then negated if s=1.
  - Max positive = 2^(OUT_W-1)-1.
  - Max negative = -2^(OUT_W-1); exact -2^(OUT_W-1) is representable and does not set o_sat.
- Classes:
  - Exponent 0 (zero or denormal) flushes to 0, including -0 → 0. o_sat=0, o_nan=0.
  - Exponent 255, mantissa 0 (±Inf): saturate to max/min with o_sat=1.
  - Exponent 255, mantissa ≠0 (NaN): o_fixed=0, o_nan=1, o_sat=0.
  - Magnitude <2^-FRAC_W gives 0; no underflow flag.
  - Magnitude ≥2^(OUT_W-1) (positive), or >2^(OUT_W-1) (negative): saturate, o_sat=1.
- Shift: amount = e-127+FRAC_W, computed in 10-bit signed.
  - Left shift for amount > 23, right shift for amount < 23.
  - Shift beyond 24 bits right gives 0.
  - No intermediate wrap is permitted: overflow is detected before truncation to OUT_W.
- Reset mid-operation: in-flight samples are discarded; no output is produced for them after release.

Optional Feature:
- Macro F2FX_ROUND_EN.
- Defined:
  - Round-to-nearest-even on the discarded magnitude bits before negation.
  - A round carry that pushes magnitude to 2^(OUT_W-1) saturates positive (o_sat=1); for negative it yields exact min with no o_sat.
  - Latency unchanged.
- Undefined: truncation toward zero as above.

Decomposition:
- Package f2fx_pkg:
  - constants EXP_W=8, MAN_W=23, EXP_BIAS=127, EXP_MAX=255
  - packed struct float32_t {sign, exponent, mantissa}
  - enum f2fx_class_e {ZERO, NORMAL, INF, NAN}
- Sub-module f2fx_align_sat: combinational shift, round/truncate, negate and saturate, parametrised by OUT_W/FRAC_W. It is instantiated between stage-1 and stage-2 registers.

Test Plan (default OUT_W=16 unless noted):
- FRAC_W=0, i_float=0x40600000 (3.5), no stall → o_fixed=0x0003 two cycles later. With F2FX_ROUND_EN → 0x0004; 0x40200000 (2.5) with ROUND → 0x0002.
- FRAC_W=8, 0x40600000 → 0x0380; 0xBF800000 (-1.0) → 0xFF00; 0x3B800000 (2^-8) → 0x0001; 0x3B000000 (2^-9) → 0x0000.
- FRAC_W=0:
  - 0x471C4000 (40000.0) → 0x7FFF, o_sat=1.
  - 0xC7000000 (-32768.0) → 0x8000, o_sat=0.
  - 0xFF800000 (-Inf) → 0x8000, o_sat=1.
- 0x7FC00000 (NaN) → 0x0000, o_nan=1. 0x80000000 (-0) and 0x00000001 (denormal) → 0x0000 with both flags 0.
- Backpressure: stream 8 back-to-back samples 1.0..8.0 with i_ready toggling 1,0,0,1… → all 8 outputs in order, none dropped or duplicated, o_fixed stable while stalled, o_ready=0 only when both stages full and i_ready=0.
- Assert i_rst for 1 cycle with 2 samples in flight → o_valid=0 immediately (async), no stale outputs after release; next accepted sample emerges after exactly 2 cycles.
